// File: rtl/vga_fifo_fill_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_fifo_fill_if
// Brief    : Memory-read and FIFO-write bundle for the VGA FIFO fill engine.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_fifo_fill_if #(
    parameter int ADDR_W = 18
) ();
    logic              frame_flag;
    logic [35:0]       vga_pixel;
    logic              done_vga;
    logic              vga_flag;
    logic [ADDR_W-1:0] vga_addr;
    logic [63:0]       f2v_din;
    logic              f2v_wr_en;
    logic              f2v_full;
    logic              busy;
    logic              frame_done;

    modport master (
        input  frame_flag,
        input  vga_pixel,
        input  done_vga,
        input  f2v_full,
        output vga_flag,
        output vga_addr,
        output f2v_din,
        output f2v_wr_en,
        output busy,
        output frame_done
    );

    modport slave (
        output frame_flag,
        output vga_pixel,
        output done_vga,
        output f2v_full,
        input  vga_flag,
        input  vga_addr,
        input  f2v_din,
        input  f2v_wr_en,
        input  busy,
        input  frame_done
    );
endinterface
`default_nettype wire

// File: rtl/vga_fifo_fill.sv
`default_nettype none
// ============================================================================
// Module   : vga_fifo_fill
// Brief    : Walks the frame in raster order, fetching pixel pairs from memory
//            and pushing tagged 64-bit words into the VGA clock-crossing FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fifo_fill #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 18
) (
    input  logic            clock,
    input  logic            reset,
    vga_fifo_fill_if.master bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_PUSH = 2'd2;

    localparam logic [9:0] c_H_LAST = 10'(H_ACTIVE - 2);
    localparam logic [9:0] c_V_LAST = 10'(V_ACTIVE - 1);

    logic [1:0]        r_state;
    logic [9:0]        r_hcount;
    logic [9:0]        r_vcount;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_din;
    logic              r_restart_pending;
    logic              r_frame_done;

    logic              w_write;
    logic              w_last_pair;

    // A restart in PUSH discards the held word, so the strobe is gated by frame_flag.
    assign w_write     = (r_state == c_PUSH) && !bus.f2v_full && !bus.frame_flag;
    assign w_last_pair = (r_hcount == c_H_LAST) && (r_vcount == c_V_LAST);

    assign bus.vga_flag   = (r_state == c_REQ);
    assign bus.busy       = (r_state != c_IDLE);
    assign bus.vga_addr   = r_addr;
    assign bus.f2v_din    = r_din;
    assign bus.f2v_wr_en  = w_write;
    assign bus.frame_done = r_frame_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state           <= c_IDLE;
            r_hcount          <= 10'd0;
            r_vcount          <= 10'd0;
            r_addr            <= '0;
            r_din             <= 64'd0;
            r_restart_pending <= 1'b0;
            r_frame_done      <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.frame_flag) begin
                        r_hcount          <= 10'd0;
                        r_vcount          <= 10'd0;
                        r_addr            <= '0;
                        r_restart_pending <= 1'b0;
                        r_state           <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (bus.done_vga) begin
                        // A restart seen during the read lets it finish, then drops its data.
                        if (r_restart_pending || bus.frame_flag) begin
                            r_hcount          <= 10'd0;
                            r_vcount          <= 10'd0;
                            r_addr            <= '0;
                            r_restart_pending <= 1'b0;
                        end else begin
                            r_din   <= {r_hcount, r_vcount, 8'd0, bus.vga_pixel};
                            r_state <= c_PUSH;
                        end
                    end else if (bus.frame_flag) begin
                        r_restart_pending <= 1'b1;
                    end
                end
                c_PUSH: begin
                    if (bus.frame_flag) begin
                        r_hcount <= 10'd0;
                        r_vcount <= 10'd0;
                        r_addr   <= '0;
                        r_state  <= c_REQ;
                    end else if (w_write) begin
                        if (w_last_pair) begin
                            r_frame_done <= 1'b1;
                            r_state      <= c_IDLE;
                        end else begin
                            if (r_hcount == c_H_LAST) begin
                                r_hcount <= 10'd0;
                                r_vcount <= r_vcount + 10'd1;
                            end else begin
                                r_hcount <= r_hcount + 10'd2;
                            end
                            r_addr  <= r_addr + 1'b1;
                            r_state <= c_REQ;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
